tilelink_to_uart_bridge: RTL and testbench



---
 rtl/tl_bridge_pkg.sv | 39 +++
 rtl/tilelink_to_uart_bridge_packet_fifo.sv | 59 +++++
 rtl/tilelink_to_uart_bridge.sv | 94 +++++++++
 tb/tb_tilelink_to_uart_bridge.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_bridge_pkg.sv
// Shared definitions for the TileLink <-> host-packet bridges: byte-lane
// offsets of the 16-byte host packet, channel IDs and the packing helper.
package tl_bridge_pkg;

    localparam int PKT_W     = 128;

    localparam int CHAN_LSB  = 0;
    localparam int OPC_LSB   = 8;
    localparam int SIZE_LSB  = 16;
    localparam int UNION_LSB = 24;
    localparam int ADDR_LSB  = 32;
    localparam int DATA_LSB  = 64;

    localparam logic [2:0] CH_A = 3'd0;
    localparam logic [2:0] CH_D = 3'd3;

    // Builds one host packet; only union[7:0] and address[31:0] fit the format.
    function automatic logic [PKT_W-1:0] pack_tl_frame(
        input logic [2:0]  chan_id,
        input logic [2:0]  opcode,
        input logic [2:0]  param,
        input logic [7:0]  size,
        input logic [7:0]  union_lo,
        input logic [31:0] address,
        input logic [63:0] data,
        input logic        corrupt
    );
        logic [PKT_W-1:0] pkt;
        pkt                  = '0;
        pkt[CHAN_LSB  +: 8]  = {5'b0, chan_id};
        pkt[OPC_LSB   +: 8]  = {corrupt, param, 1'b0, opcode};
        pkt[SIZE_LSB  +: 8]  = size;
        pkt[UNION_LSB +: 8]  = union_lo;
        pkt[ADDR_LSB  +: 32] = address;
        pkt[DATA_LSB  +: 64] = data;
        return pkt;
    endfunction

endpackage

// File: rtl/tilelink_to_uart_bridge_packet_fifo.sv
// Synchronous FIFO with asynchronous active-high reset. Pointers and the
// occupancy count carry one extra bit so that DEPTH itself is representable.
// Push is ignored when full and pop is ignored when empty.
module packet_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == PTR_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr[IDX_W-1:0]];

    // Storage, pointers and occupancy; reset clears everything so the head reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[IDX_W-1:0]] <= push_data;
                wr_ptr                 <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + PTR_W'(1);
                2'b01:   count <= count - PTR_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tilelink_to_uart_bridge.sv
// Return-path bridge: packs single-beat TileLink frames into 16-byte host
// packets, queues them in a small FIFO and keeps bring-up debug counters.
//
// Handshakes: a transfer happens on a rising tl_clk edge where both valid
// and ready are high. Producers hold valid and data steady until that edge;
// tl_out_ready depends only on FIFO occupancy (no same-cycle pop look-ahead);
// packet_valid stays high and packet_data stays stable until accepted.
module tilelink_to_uart_bridge
    import tl_bridge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              tl_clk,
    input  logic              reset,
    input  logic              tl_out_valid,
    output logic              tl_out_ready,
    input  logic [2:0]        tl_out_bits_chanId,
    input  logic [2:0]        tl_out_bits_opcode,
    input  logic [2:0]        tl_out_bits_param,
    input  logic [7:0]        tl_out_bits_size,
    input  logic [7:0]        tl_out_bits_source,
    input  logic [63:0]       tl_out_bits_address,
    input  logic [63:0]       tl_out_bits_data,
    input  logic              tl_out_bits_corrupt,
    input  logic [8:0]        tl_out_bits_union,
    input  logic              tl_out_bits_last,
    output logic              packet_valid,
    input  logic              packet_ready,
    output logic [PKT_W-1:0]  packet_data,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  error_count,
    output logic              union_trunc
);

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   accept;
    logic                   is_error;
    logic [PKT_W-1:0]       packed_frame;
    logic                   unused_bits;

    // Fields that the host format has no room for, plus the spare occupancy.
    assign unused_bits = ^{tl_out_bits_source, tl_out_bits_address[63:32],
                           tl_out_bits_last, fifo_count};

    assign tl_out_ready = ~fifo_full;
    assign packet_valid = ~fifo_empty;
    assign accept       = tl_out_valid & ~fifo_full;

    // Denied (union bit 0) or corrupt responses on channel D are errors.
    assign is_error     = (tl_out_bits_chanId == CH_D) &
                          (tl_out_bits_corrupt | tl_out_bits_union[0]);

    assign packed_frame = pack_tl_frame(tl_out_bits_chanId, tl_out_bits_opcode,
                                        tl_out_bits_param, tl_out_bits_size,
                                        tl_out_bits_union[7:0],
                                        tl_out_bits_address[31:0],
                                        tl_out_bits_data, tl_out_bits_corrupt);

    packet_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (tl_clk),
        .rst       (reset),
        .push      (accept),
        .push_data (packed_frame),
        .pop       (packet_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (packet_data)
    );

    // Debug counters: frames wrap, errors saturate, truncation flag is sticky.
    always_ff @(posedge tl_clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
            error_count <= '0;
            union_trunc <= 1'b0;
        end else if (accept) begin
            frame_count <= frame_count + CNT_W'(1);
            if (is_error && (error_count != '1)) begin
                error_count <= error_count + CNT_W'(1);
            end
            if (tl_out_bits_union[8]) begin
                union_trunc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tilelink_to_uart_bridge.sv
// Bench for tilelink_to_uart_bridge: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the bridge.
module tb_tilelink_to_uart_bridge;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic          tl_clk = 1'b0;
    logic          reset;
    logic          tl_out_valid;
    logic          tl_out_ready;
    logic [2:0]    ch;
    logic [2:0]    opc;
    logic [2:0]    prm;
    logic [7:0]    sz;
    logic [7:0]    src;
    logic [63:0]   addr;
    logic [63:0]   dat;
    logic          cor;
    logic [8:0]    uni;
    logic          lst;
    logic          packet_valid;
    logic          packet_ready;
    logic [127:0]  packet_data;
    logic [CNT_W-1:0] frame_count;
    logic [CNT_W-1:0] error_count;
    logic          union_trunc;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [127:0] exp_q[$];
    int           m_frames;
    int           m_errs;
    bit           m_trunc;

    // ---------------- clock / reset ----------------
    always #5 tl_clk = ~tl_clk;

    tilelink_to_uart_bridge #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .tl_clk              (tl_clk),
        .reset               (reset),
        .tl_out_valid        (tl_out_valid),
        .tl_out_ready        (tl_out_ready),
        .tl_out_bits_chanId  (ch),
        .tl_out_bits_opcode  (opc),
        .tl_out_bits_param   (prm),
        .tl_out_bits_size    (sz),
        .tl_out_bits_source  (src),
        .tl_out_bits_address (addr),
        .tl_out_bits_data    (dat),
        .tl_out_bits_corrupt (cor),
        .tl_out_bits_union   (uni),
        .tl_out_bits_last    (lst),
        .packet_valid        (packet_valid),
        .packet_ready        (packet_ready),
        .packet_data         (packet_data),
        .frame_count         (frame_count),
        .error_count         (error_count),
        .union_trunc         (union_trunc)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Host packet built byte by byte from the field layout.
    function automatic logic [127:0] model_pack();
        logic [7:0]   b [16];
        logic [127:0] p;
        b[0] = {5'b0, ch};
        b[1] = {cor, prm, 1'b0, opc};
        b[2] = sz;
        b[3] = uni[7:0];
        for (int i = 0; i < 4; i++) b[4 + i] = addr[8*i +: 8];
        for (int i = 0; i < 8; i++) b[8 + i] = dat[8*i +: 8];
        p = '0;
        for (int i = 0; i < 16; i++) p[8*i +: 8] = b[i];
        return p;
    endfunction

    // ---------------- reference model ----------------
    always @(posedge tl_clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_frames = 0;
            m_errs   = 0;
            m_trunc  = 1'b0;
        end else begin
            bit acc;
            bit pop;
            acc = (tl_out_valid === 1'b1) && (exp_q.size() < DEPTH);
            pop = (packet_ready === 1'b1) && (exp_q.size() > 0);
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(model_pack());
                m_frames = (m_frames + 1) % (1 << CNT_W);
                if (ch == 3'd3 && (cor || uni[0]) && m_errs < (1 << CNT_W) - 1) m_errs++;
                if (uni[8]) m_trunc = 1'b1;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge tl_clk) begin
        if (reset === 1'b0) begin
            check("tl_out_ready", 128'(tl_out_ready), 128'(exp_q.size() < DEPTH));
            check("packet_valid", 128'(packet_valid), 128'(exp_q.size() > 0));
            if (exp_q.size() > 0) check("packet_data", packet_data, exp_q[0]);
            check("frame_count", 128'(frame_count), 128'(m_frames));
            check("error_count", 128'(error_count), 128'(m_errs));
            check("union_trunc", 128'(union_trunc), 128'(m_trunc));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge tl_clk);
        #1;
    endtask

    task automatic set_frame(input logic [2:0] c, input logic [2:0] o, input logic [2:0] p,
                             input logic [7:0] s, input logic [8:0] u, input logic [63:0] a,
                             input logic [63:0] d, input logic k);
        ch = c; opc = o; prm = p; sz = s; uni = u; addr = a; dat = d; cor = k;
        src = 8'($urandom_range(0, 255));
        lst = 1'b1;
    endtask

    // Presents a frame and holds it until the bridge takes it (bounded wait).
    task automatic send(input logic [2:0] c, input logic [2:0] o, input logic [2:0] p,
                        input logic [7:0] s, input logic [8:0] u, input logic [63:0] a,
                        input logic [63:0] d, input logic k);
        logic rdy;
        set_frame(c, o, p, s, u, a, d, k);
        tl_out_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            rdy = tl_out_ready;
            step();
            if (rdy) begin
                tl_out_valid = 1'b0;
                return;
            end
        end
        tl_out_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout frame not accepted within 50 cycles, required acceptance");
    endtask

    task automatic do_reset();
        @(posedge tl_clk);
        #3 reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        tl_out_valid = 1'b0;
        packet_ready = 1'b0;
        set_frame(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        reset = 1'b0;
        check("reset_ready", 128'(tl_out_ready), 128'(1));
        check("reset_valid", 128'(packet_valid), 128'(0));
        check("reset_data", packet_data, 128'(0));
        check("reset_frames", 128'(frame_count), 128'(0));

        // Single pack, visible one cycle after accept
        send(3, 1, 0, 3, 0, 64'h8000_1000, 64'h1122_3344_5566_7788, 0);
        check("single_pack", packet_data, 128'h1122334455667788_80001000_00030103);
        check("single_frames", 128'(frame_count), 128'(1));

        // Reset with two entries queued
        send(0, 4, 1, 2, 9'h0F, 64'h1234, 64'hABCD, 0);
        @(posedge tl_clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_valid", 128'(packet_valid), 128'(0));
        check("midrst_ready", 128'(tl_out_ready), 128'(1));
        check("midrst_frames", 128'(frame_count), 128'(0));
        step();
        reset = 1'b0;
        check("postrst_valid", 128'(packet_valid), 128'(0));
        check("postrst_data", packet_data, 128'(0));

        // Backpressure: four fit, fifth waits for a pop
        packet_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(3, 1, 0, 3, 0, 64'(i * 16), 64'(i), 0);
        check("full_ready", 128'(tl_out_ready), 128'(0));
        set_frame(3, 1, 0, 3, 0, 64'h50, 64'd5, 0);
        tl_out_valid = 1'b1;
        step();
        check("full_hold_ready", 128'(tl_out_ready), 128'(0));
        check("full_head", packet_data[127:64], 128'(1));
        packet_ready = 1'b1;
        step();
        packet_ready = 1'b0;
        check("ready_after_pop", 128'(tl_out_ready), 128'(1));
        step();
        tl_out_valid = 1'b0;
        check("fifth_taken", 128'(tl_out_ready), 128'(0));
        packet_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("drain_order", packet_data[127:64], 128'(i));
            step();
        end
        packet_ready = 1'b0;
        check("drained_empty", 128'(packet_valid), 128'(0));

        // Simultaneous push/pop at occupancy 2
        send(3, 1, 0, 3, 0, 0, 64'd50, 0);
        send(3, 1, 0, 3, 0, 0, 64'd51, 0);
        packet_ready = 1'b1;
        tl_out_valid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            set_frame(3, 1, 0, 3, 0, 64'(j), 64'(100 + j), 0);
            step();
            check("pushpop_ready", 128'(tl_out_ready), 128'(1));
        end
        tl_out_valid = 1'b0;
        packet_ready = 1'b0;
        check("pushpop_head", packet_data[127:64], 128'(108));
        packet_ready = 1'b1;
        step();
        check("pushpop_tail", packet_data[127:64], 128'(109));
        step();
        packet_ready = 1'b0;
        check("pushpop_empty", 128'(packet_valid), 128'(0));

        // Error counting and saturation
        do_reset();
        packet_ready = 1'b1;
        send(3, 1, 0, 3, 9'h001, 0, 64'd1, 0);
        send(3, 1, 0, 3, 9'h000, 0, 64'd2, 1);
        send(0, 1, 0, 3, 9'h000, 0, 64'd3, 1);
        check("err_count", 128'(error_count), 128'(2));
        check("err_frames", 128'(frame_count), 128'(3));
        for (int i = 0; i < 16; i++) send(3, 1, 0, 3, 9'h001, 0, 64'(i), 1);
        check("err_saturate", 128'(error_count), 128'(4'hF));
        check("frames_wrap", 128'(frame_count), 128'(3));
        step();
        step();

        // Union truncation flag
        packet_ready = 1'b0;
        send(0, 2, 0, 1, 9'h1A5, 64'h10, 64'h20, 0);
        check("trunc_byte3", 128'(packet_data[31:24]), 128'(8'hA5));
        check("trunc_flag", 128'(union_trunc), 128'(1));
        packet_ready = 1'b1;
        send(0, 2, 0, 1, 9'h0FF, 64'h10, 64'h21, 0);
        step();
        check("trunc_sticky", 128'(union_trunc), 128'(1));
        do_reset();
        check("trunc_cleared", 128'(union_trunc), 128'(0));

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            set_frame(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      8'($urandom_range(0, 255)),
                      {($urandom_range(0, 31) == 0), 8'($urandom_range(0, 255))},
                      {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            tl_out_valid = ($urandom_range(0, 3) != 0);
            packet_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        tl_out_valid = 1'b0;
        packet_ready = 1'b1;
        repeat (DEPTH + 2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
